amo_responder: RTL and testbench
================================

# amo_responder

Memory-side responder for atomic memory operations in the data-memory path. It accepts one AMO request per handshake (opcode, word address, rs2 operand) and reads the addressed word from a synchronous data RAM. It applies the operator, writes the result back and returns the original loaded value for rd. It sits between the core's AMO request port and the data RAM and serialises each read-modify-write, so no other memory access from this port can interleave.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous active-high reset.
- req_valid  in  1  AMO request valid.
- req_ready  out  1  responder can accept a request.
- req_amoop  in  amoop_t  operation.
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- req_data  in  DATA_WIDTH  rs2 operand.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_WIDTH  original memory word, destined for rd.
- mem_rd_req  out  1  RAM read strobe.
- mem_wr_req  out  1  RAM write strobe.
- mem_addr  out  ADDR_WIDTH  word-aligned RAM address.
- mem_wdata  out  DATA_WIDTH  modified word.
- mem_mask  out  DATA_WIDTH/8  byte enables; 4'b1111 on every write.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_rd_req.

## Operation
The FSM has five states: IDLE, RD, CALC, WR, RSP.

- **IDLE**
  - req_ready=1.
  - When req_valid is high: capture op, {addr[ADDR_WIDTH-1:2],2'b00} and req_data, then go to RD.
- **RD**
  - mem_rd_req=1 and mem_addr=captured address, for one cycle. Go to CALC.
- **CALC**
  - Register old=mem_rdata.
  - Register new=f(old, operand):
    - ADD: wraps modulo 2^32.
    - SWAP: operand.
    - XOR, AND, OR: bitwise.
    - MIN, MAX: signed compare.
    - MINU, MAXU: unsigned compare.
  - Go to WR. For an unknown opcode, skip WR and go to RSP.
- **WR**
  - mem_wr_req=1, mem_addr held, mem_wdata=new, for one cycle. Go to RSP.
- **RSP**
  - rsp_valid=1 and rsp_data=old.
  - Hold both until rsp_ready is high, then go to IDLE.
  - rsp_data stays stable while rsp_valid && !rsp_ready.

General rules:
- Only one operation is in flight at a time.
- req_ready=0 in every state except IDLE.
- mem_rd_req and mem_wr_req are never high in the same cycle.
- Reset (including mid-operation):
  - State returns to IDLE and all registers clear.
  - Every output is 0 except mem_mask, which is 4'b1111 (constant).
  - A pending write is dropped. If arst is asserted during WR, whether the RAM takes that write depends on RAM timing; the bench must not rely on it.

## Timing
- Request accepted at edge 0.
- RD in cycle 1, CALC in cycle 2, WR in cycle 3, rsp_valid from cycle 4.
- Minimum occupancy is 5 cycles, plus one cycle per rsp_ready stall.
- With rsp_ready held high, req_ready returns in cycle 5, giving back-to-back throughput of one op per 5 cycles.
- Unknown opcode: rsp_valid from cycle 3 and no write is issued.

## Configuration
- **AMO_LRSC_EN defined**
  - amoop_t gains LR_W and SC_W, and the block holds a single reservation register (valid + word address).
  - LR_W: read only (RD→CALC→RSP). Sets reservation={1,addr} and returns the loaded word.
  - SC_W: goes RD→CALC. If the reservation is valid and the address matches, WR stores the operand and rsp_data=0. Otherwise there is no write and rsp_data=1. The reservation clears in both cases.
  - Any AMO write to the reserved address clears the reservation.
- **AMO_LRSC_EN undefined**
  - There is no reservation logic, and LR_W and SC_W do not exist.

## Structure
- The shared amo_pkg holds:
  - amoop_t;
  - the opcode constants (LR_W and SC_W guarded by AMO_LRSC_EN);
  - the FSM state enum amo_rsp_state_t.
- The sub-module amo_alu is a combinational op, old, operand → new; the existing AMO datapath can reuse it.

## Test plan
1. Memory[0x10]=5; AMOADD_W, addr 0x10, data 3 → rsp_data=5, memory[0x10]=8, rsp_valid in cycle 4.
2. Memory[0x20]=0xFFFFFFFF; AMOMIN_W data 1 → rsp_data=0xFFFFFFFF, memory unchanged at 0xFFFFFFFF. AMOMINU_W data 1 on the same word → memory=1.
3. AMOSWAP_W addr 0x13 (misaligned), data 0xA5A5A5A5 → RAM sees address 0x10, mask 4'b1111.
4. rsp_ready held low for 3 cycles → rsp_valid and rsp_data stable throughout, req_ready=0 throughout, exactly one mem_wr_req pulse.
5. arst pulsed in the CALC state → all outputs 0 asynchronously, no mem_wr_req afterwards, next request completes normally.
6. (AMO_LRSC_EN) LR_W 0x40 then SC_W 0x40 data 7 → rsp_data=0, memory=7. A second SC_W → rsp_data=1, no write.

Source files
------------

// File: rtl/amo_pkg.sv
// Shared AMO types: operation encoding (funct5-style) and responder FSM states.
// LR_W/SC_W exist only when AMO_LRSC_EN is defined.
package amo_pkg;

    typedef enum logic [4:0] {
        AMOADD_W  = 5'b00000,
        AMOSWAP_W = 5'b00001,
`ifdef AMO_LRSC_EN
        LR_W      = 5'b00010,
        SC_W      = 5'b00011,
`endif
        AMOXOR_W  = 5'b00100,
        AMOOR_W   = 5'b01000,
        AMOAND_W  = 5'b01100,
        AMOMIN_W  = 5'b10000,
        AMOMAX_W  = 5'b10100,
        AMOMINU_W = 5'b11000,
        AMOMAXU_W = 5'b11100
    } amoop_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_WR,
        ST_RSP
    } amo_rsp_state_t;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO operator: (op, old, operand) -> result; known=0 for opcodes it does not implement.
// Zero latency, no flow control.
module amo_alu
    import amo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  amoop_t                op,
    input  logic [DATA_WIDTH-1:0] old,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  known
);

    always_comb begin
        result = old;
        known  = 1'b1;
        case (op)
            AMOADD_W:  result = old + operand;
            AMOSWAP_W: result = operand;
            AMOXOR_W:  result = old ^ operand;
            AMOAND_W:  result = old & operand;
            AMOOR_W:   result = old | operand;
            AMOMIN_W:  result = ($signed(old) < $signed(operand)) ? old : operand;
            AMOMAX_W:  result = ($signed(old) > $signed(operand)) ? old : operand;
            AMOMINU_W: result = (old < operand) ? old : operand;
            AMOMAXU_W: result = (old > operand) ? old : operand;
            default:   known  = 1'b0;
        endcase
    end

endmodule

// File: rtl/amo_responder.sv
// Serialised AMO read-modify-write against a sync RAM: rsp_valid 4 cycles after accept (3 if no write),
// req_ready only in IDLE, response held until rsp_ready. AMO_LRSC_EN adds LR_W/SC_W with one reservation.
module amo_responder
    import amo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  amoop_t                  req_amoop,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    amo_rsp_state_t        state_q, state_d;
    amoop_t                op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] opnd_q, old_q, new_q;
    logic [DATA_WIDTH-1:0] alu_result, calc_old, calc_new;
    logic                  alu_known, do_write;

    amo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op      (op_q),
        .old     (mem_rdata),
        .operand (opnd_q),
        .result  (alu_result),
        .known   (alu_known)
    );

`ifdef AMO_LRSC_EN
    logic                  resv_vld_q;
    logic [ADDR_WIDTH-1:0] resv_addr_q;
    logic                  sc_ok;

    assign sc_ok = resv_vld_q && (resv_addr_q == addr_q);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            resv_vld_q  <= 1'b0;
            resv_addr_q <= '0;
        end else if (state_q == ST_CALC) begin
            if (op_q == LR_W) begin
                resv_vld_q  <= 1'b1;
                resv_addr_q <= addr_q;
            end else if (op_q == SC_W || (do_write && resv_addr_q == addr_q)) begin
                resv_vld_q  <= 1'b0;
            end
        end
    end

    // SC reports success as 0 in the rd slot; LR is a plain read with no write-back.
    always_comb begin
        calc_old = mem_rdata;
        calc_new = alu_result;
        do_write = alu_known;
        if (op_q == LR_W) begin
            do_write = 1'b0;
        end else if (op_q == SC_W) begin
            do_write = sc_ok;
            calc_old = sc_ok ? '0 : DATA_WIDTH'(1);
            calc_new = opnd_q;
        end
    end
`else
    always_comb begin
        calc_old = mem_rdata;
        calc_new = alu_result;
        do_write = alu_known;
    end
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            op_q    <= amoop_t'('0);
            addr_q  <= '0;
            opnd_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                op_q   <= req_amoop;
                addr_q <= req_addr & WORD_MASK;
                opnd_q <= req_data;
            end
            if (state_q == ST_CALC) begin
                old_q <= calc_old;
                new_q <= calc_new;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE: begin
                // Gated so the port reads 0 for the whole reset pulse, not just after the edge.
                req_ready = !arst;
                if (req_valid) state_d = ST_RD;
            end
            ST_RD: begin
                mem_rd_req = 1'b1;
                mem_addr   = addr_q;
                state_d    = ST_CALC;
            end
            ST_CALC: begin
                state_d = do_write ? ST_WR : ST_RSP;
            end
            ST_WR: begin
                mem_wr_req = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = new_q;
                state_d    = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = old_q;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_mask = '1;

endmodule

// File: tb/tb_amo_responder.sv
// Bench for amo_responder: vector table, reset/stall/LR-SC sequences, then random ops against a memory model.
module tb_amo_responder;
    import amo_pkg::*;

    logic         clk;
    logic         arst;
    logic         req_valid;
    logic         req_ready;
    amoop_t       req_amoop;
    logic [31:0]  req_addr;
    logic [31:0]  req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_mask;
    logic [31:0]  mem_rdata;

    amo_responder dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_amoop  (req_amoop),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Synchronous RAM plus bus monitor.
    logic [31:0] ram [0:255];
    logic        fill;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    int          wr_pulses = 0;
    int          both_hi = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_rd_addr = '0;
    logic [3:0]  last_wr_mask = '0;

    function automatic logic [31:0] fill_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A50000;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= fill_word(i);
        end else if (pre_we) begin
            ram[pre_idx] <= pre_val;
        end
        if (mem_wr_req) begin
            ram[mem_addr[9:2]] <= mem_wdata;
            wr_pulses    <= wr_pulses + 1;
            last_wr_addr <= mem_addr;
            last_wr_mask <= mem_mask;
        end
        if (mem_rd_req) begin
            mem_rdata    <= ram[mem_addr[9:2]];
            last_rd_addr <= mem_addr;
        end
        if (mem_rd_req && mem_wr_req) both_hi <= both_hi + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] v);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = addr[9:2];
        pre_val = v;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // One full transaction; expected write/no-write fixes the expected latency (4 vs 3).
    task automatic run_op(input string tag, input amoop_t op, input logic [31:0] addr,
                          input logic [31:0] data, input int stall,
                          input logic [31:0] exp_rsp, input bit exp_wr, input logic [31:0] exp_mem);
        int   cyc;
        int   wr0;
        logic rdy_seen;
        logic [31:0] waddr;
        waddr = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        chk($sformatf("%s.idle_ready", tag), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_amoop = op;
        req_addr  = addr;
        req_data  = data;
        rsp_ready = (stall == 0);
        wr0 = wr_pulses;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = $urandom;
        cyc = 1;
        rdy_seen = 1'b0;
        while (!rsp_valid && cyc < 12) begin
            rdy_seen = rdy_seen | req_ready;
            @(negedge clk);
            cyc++;
        end
        rdy_seen = rdy_seen | req_ready;
        chk($sformatf("%s.latency", tag), 32'(cyc), exp_wr ? 32'd4 : 32'd3);
        chk($sformatf("%s.rd_addr", tag), last_rd_addr, waddr);
        for (int i = 0; i < stall; i++) begin
            chk($sformatf("%s.stall_valid", tag), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("%s.stall_data", tag), rsp_data, exp_rsp);
            rdy_seen = rdy_seen | req_ready;
            @(negedge clk);
        end
        chk($sformatf("%s.rsp_valid", tag), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("%s.rsp_data", tag), rsp_data, exp_rsp);
        rdy_seen = rdy_seen | req_ready;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%s.ready_back", tag), {30'b0, req_ready, rsp_valid}, 32'd2);
        chk($sformatf("%s.busy_not_ready", tag), {31'b0, rdy_seen}, 32'd0);
        chk($sformatf("%s.wr_pulses", tag), 32'(wr_pulses - wr0), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) begin
            chk($sformatf("%s.wr_addr", tag), last_wr_addr, waddr);
            chk($sformatf("%s.wr_mask", tag), {28'b0, last_wr_mask}, 32'hF);
        end
        chk($sformatf("%s.mem", tag), ram[addr[9:2]], exp_mem);
    endtask

    // Reference semantics of each AMO: new memory word and whether a write happens.
    function automatic void amo_model(input amoop_t op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output bit wr);
        wr = 1'b1;
        case (op)
            AMOADD_W:  r = a + b;
            AMOSWAP_W: r = b;
            AMOXOR_W:  r = a ^ b;
            AMOAND_W:  r = a & b;
            AMOOR_W:   r = a | b;
            AMOMIN_W:  r = (int'(a) < int'(b)) ? a : b;
            AMOMAX_W:  r = (int'(a) > int'(b)) ? a : b;
            AMOMINU_W: r = (a < b) ? a : b;
            AMOMAXU_W: r = (a > b) ? a : b;
            default: begin
                r  = a;
                wr = 1'b0;
            end
        endcase
    endfunction

    typedef struct {
        amoop_t      op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          pre;
        logic [31:0] pre_val;
        int          stall;
        logic [31:0] exp_rsp;
        bit          exp_wr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t        vecs [13];
    amoop_t      rand_ops [10];
    logic [31:0] ref_mem [0:255];

    initial begin
        logic [31:0] old_v;
        logic [31:0] new_v;
        bit          wr_v;
        logic [31:0] ra;
        logic [31:0] rd;
        amoop_t      rop;
        int          wr0;

        vecs[0]  = '{AMOADD_W,  32'h10, 32'd3,         1'b1, 32'd5,         0, 32'd5,         1'b1, 32'd8};
        vecs[1]  = '{AMOMIN_W,  32'h20, 32'd1,         1'b1, 32'hFFFFFFFF,  0, 32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF};
        vecs[2]  = '{AMOMINU_W, 32'h20, 32'd1,         1'b0, 32'd0,         0, 32'hFFFFFFFF,  1'b1, 32'd1};
        vecs[3]  = '{AMOSWAP_W, 32'h13, 32'hA5A5A5A5,  1'b0, 32'd0,         0, 32'd8,         1'b1, 32'hA5A5A5A5};
        vecs[4]  = '{AMOXOR_W,  32'h30, 32'hFF00FF00,  1'b1, 32'hF0F0F0F0,  0, 32'hF0F0F0F0,  1'b1, 32'h0FF00FF0};
        vecs[5]  = '{AMOAND_W,  32'h30, 32'h00FFFF00,  1'b0, 32'd0,         0, 32'h0FF00FF0,  1'b1, 32'h00F00F00};
        vecs[6]  = '{AMOOR_W,   32'h34, 32'h00005678,  1'b1, 32'h12340000,  0, 32'h12340000,  1'b1, 32'h12345678};
        vecs[7]  = '{AMOMAX_W,  32'h38, 32'd5,         1'b1, 32'h80000000,  0, 32'h80000000,  1'b1, 32'd5};
        vecs[8]  = '{AMOMAXU_W, 32'h3C, 32'd5,         1'b1, 32'h80000000,  0, 32'h80000000,  1'b1, 32'h80000000};
        vecs[9]  = '{AMOADD_W,  32'h44, 32'd2,         1'b1, 32'hFFFFFFFF,  0, 32'hFFFFFFFF,  1'b1, 32'd1};
        vecs[10] = '{AMOMIN_W,  32'h48, 32'hFFFFFFFE,  1'b1, 32'd3,         0, 32'd3,         1'b1, 32'hFFFFFFFE};
        vecs[11] = '{amoop_t'(5'b00101), 32'h4C, 32'h22, 1'b1, 32'h11,       0, 32'h11,        1'b0, 32'h11};
        vecs[12] = '{AMOADD_W,  32'h50, 32'd1,         1'b1, 32'd100,       3, 32'd100,       1'b1, 32'd101};

        rand_ops = '{AMOADD_W, AMOSWAP_W, AMOXOR_W, AMOAND_W, AMOOR_W,
                     AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W, amoop_t'(5'b00101)};

        arst      = 1'b1;
        fill      = 1'b1;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_val   = '0;
        req_valid = 1'b0;
        req_amoop = AMOADD_W;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        fill = 1'b0;
        #1;
        chk("reset.outputs", {req_ready, rsp_valid, mem_rd_req, mem_wr_req, 28'b0}, 32'd0);
        chk("reset.rsp_data", rsp_data, 32'd0);
        chk("reset.mem_addr", mem_addr, 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.mem_mask", {28'b0, mem_mask}, 32'hF);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk("post_reset.ready", {30'b0, req_ready, rsp_valid}, 32'd2);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].pre) preload(vecs[i].addr, vecs[i].pre_val);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].stall,
                   vecs[i].exp_rsp, vecs[i].exp_wr, vecs[i].exp_mem);
        end

        // Asynchronous reset while the operation sits in CALC.
        preload(32'h60, 32'd9);
        @(negedge clk);
        req_valid = 1'b1;
        req_amoop = AMOADD_W;
        req_addr  = 32'h60;
        req_data  = 32'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        arst = 1'b1;
        wr0  = wr_pulses;
        #1;
        chk("arst.outputs", {req_ready, rsp_valid, mem_rd_req, mem_wr_req, 28'b0}, 32'd0);
        chk("arst.rsp_data", rsp_data, 32'd0);
        chk("arst.mem_addr", mem_addr, 32'd0);
        chk("arst.mem_wdata", mem_wdata, 32'd0);
        chk("arst.mem_mask", {28'b0, mem_mask}, 32'hF);
        @(negedge clk);
        arst = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst.no_write", 32'(wr_pulses - wr0), 32'd0);
        chk("arst.idle_ready", {30'b0, req_ready, rsp_valid}, 32'd2);
        chk("arst.mem_kept", ram[8'h18], 32'd9);
        run_op("arst.next", AMOADD_W, 32'h60, 32'd1, 0, 32'd9, 1'b1, 32'd10);

`ifdef AMO_LRSC_EN
        preload(32'h40, 32'h77);
        run_op("lr", LR_W, 32'h40, 32'd0, 0, 32'h77, 1'b0, 32'h77);
        run_op("sc_ok", SC_W, 32'h40, 32'd7, 0, 32'd0, 1'b1, 32'd7);
        run_op("sc_again", SC_W, 32'h40, 32'd9, 0, 32'd1, 1'b0, 32'd7);
        run_op("lr2", LR_W, 32'h41, 32'd0, 0, 32'd7, 1'b0, 32'd7);
        run_op("amo_kill", AMOADD_W, 32'h40, 32'd1, 0, 32'd7, 1'b1, 32'd8);
        run_op("sc_killed", SC_W, 32'h40, 32'd3, 1, 32'd1, 1'b0, 32'd8);
`endif

        @(negedge clk);
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = fill_word(i);

        for (int n = 0; n < 150; n++) begin
            rop = rand_ops[$urandom_range(0, 9)];
            ra  = 32'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0:       rd = 32'h80000000 | 32'($urandom_range(0, 3));
                1:       rd = 32'($urandom_range(0, 7));
                default: rd = $urandom;
            endcase
            old_v = ref_mem[ra[9:2]];
            amo_model(rop, old_v, rd, new_v, wr_v);
            if (wr_v) ref_mem[ra[9:2]] = new_v;
            run_op($sformatf("rand%0d", n), rop, ra, rd, $urandom_range(0, 2), old_v, wr_v, ref_mem[ra[9:2]]);
        end

        chk("rd_wr_exclusive", 32'(both_hi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
